board_mem_sched: RTL and testbench



---
 rtl/board_mem_sched.sv | 168 ++++++++++++++++
 tb/tb_board_mem_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_sched.sv
// Single-port board BRAM scheduler: renderer owns active video, edits then updater share the blank.
// Latency: renderer 0 cycles (combinational mux); updater read data 1 cycle after grant; edit ack 3 cycles after EDIT_RD.
// Backpressure: updater holds upd_req_in until upd_gnt_out; one edit in flight, further edit_req_in ignored while busy. Macro: BOARD_SCHED_FRAME_GATE_EN.
module board_mem_sched #(
    parameter int WORD_SIZE     = 16,
    parameter int LOG_WORD_SIZE = 4,
    parameter int LOG_MAX_ADDR  = 15,
    parameter int GEN_PERIOD    = 4
) (
    input  logic                     clk_130mhz,
    input  logic                     rst_n_in,
    input  logic                     render_done_in,
    input  logic [LOG_MAX_ADDR-1:0]  render_addr_in,
    input  logic                     upd_req_in,
    input  logic                     upd_we_in,
    input  logic [LOG_MAX_ADDR-1:0]  upd_addr_in,
    input  logic [WORD_SIZE-1:0]     upd_wdata_in,
    output logic                     upd_gnt_out,
    output logic                     upd_rvalid_out,
    input  logic                     edit_req_in,
    input  logic [LOG_MAX_ADDR-1:0]  edit_addr_in,
    input  logic [LOG_WORD_SIZE-1:0] edit_bit_in,
    output logic                     edit_busy_out,
    output logic                     edit_ack_out,
    output logic                     gen_start_out,
    output logic [LOG_MAX_ADDR-1:0]  mem_addr_out,
    output logic                     mem_we_out,
    output logic [WORD_SIZE-1:0]     mem_wdata_out,
    input  logic [WORD_SIZE-1:0]     mem_rdata_in,
    output logic [WORD_SIZE-1:0]     rdata_out
);

    typedef enum logic [2:0] {
        ST_RENDER,
        ST_BLANK,
        ST_EDIT_RD,
        ST_EDIT_MOD,
        ST_EDIT_WR
    } state_t;

    state_t                     state_q;
    logic                       busy_q;
    logic [LOG_MAX_ADDR-1:0]    edit_addr_q;
    logic [LOG_WORD_SIZE-1:0]   edit_bit_q;
    logic [WORD_SIZE-1:0]       word_q;
    logic                       done_prev_q;
    logic                       ack_q;
    logic                       gen_start_q;
    logic                       rvalid_q;

    logic                       done_rise;
    logic                       elig;
    logic                       elig_at_edge;
    logic                       edit_take;
    logic                       gnt;
    logic [LOG_WORD_SIZE-1:0]   bit_pos;
    logic [WORD_SIZE-1:0]       flip_mask;

    assign done_rise = render_done_in & ~done_prev_q;
    assign edit_take = edit_req_in & ~busy_q;

`ifdef BOARD_SCHED_FRAME_GATE_EN
    logic [7:0] frame_cnt_q;
    logic       elig_q;

    // Eligibility is decided at the blank's rising edge and held for the whole blank.
    assign elig_at_edge = (frame_cnt_q == 8'd0);
    assign elig         = elig_q;

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt_q <= 8'd0;
            elig_q      <= 1'b1;
        end else if (done_rise) begin
            elig_q      <= (frame_cnt_q == 8'd0);
            frame_cnt_q <= (frame_cnt_q == 8'(GEN_PERIOD - 1)) ? 8'd0 : frame_cnt_q + 8'd1;
        end
    end
`else
    assign elig_at_edge = 1'b1;
    assign elig         = 1'b1;
`endif

    // A same-cycle edit request wins over the updater.
    assign gnt = render_done_in && (state_q == ST_BLANK) && !busy_q && !edit_req_in
                 && elig && upd_req_in;

    // Cell 0 is the MSB of the word.
    assign bit_pos   = LOG_WORD_SIZE'(WORD_SIZE - 1) - edit_bit_q;
    assign flip_mask = {{(WORD_SIZE-1){1'b0}}, 1'b1} << bit_pos;

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_RENDER;
            busy_q      <= 1'b0;
            edit_addr_q <= '0;
            edit_bit_q  <= '0;
            word_q      <= '0;
            done_prev_q <= 1'b1;
            ack_q       <= 1'b0;
            gen_start_q <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            done_prev_q <= render_done_in;
            rvalid_q    <= gnt & ~upd_we_in;
            gen_start_q <= done_rise & elig_at_edge;
            ack_q       <= 1'b0;
            if (edit_take) begin
                busy_q      <= 1'b1;
                edit_addr_q <= edit_addr_in;
                edit_bit_q  <= edit_bit_in;
            end
            // Leaving blank mid-edit keeps busy set so the edit restarts next blank.
            if (!render_done_in) begin
                state_q <= ST_RENDER;
            end else begin
                case (state_q)
                    ST_RENDER:   state_q <= ST_BLANK;
                    ST_BLANK:    if (busy_q || edit_req_in) state_q <= ST_EDIT_RD;
                    ST_EDIT_RD:  state_q <= ST_EDIT_MOD;
                    ST_EDIT_MOD: begin
                        word_q  <= mem_rdata_in ^ flip_mask;
                        state_q <= ST_EDIT_WR;
                    end
                    ST_EDIT_WR: begin
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= ST_BLANK;
                    end
                    default:     state_q <= ST_RENDER;
                endcase
            end
        end
    end

    always_comb begin
        mem_addr_out  = render_addr_in;
        mem_we_out    = 1'b0;
        mem_wdata_out = upd_wdata_in;
        if (render_done_in) begin
            case (state_q)
                ST_BLANK: begin
                    mem_addr_out = upd_addr_in;
                    mem_we_out   = gnt & upd_we_in;
                end
                ST_EDIT_RD, ST_EDIT_MOD: begin
                    mem_addr_out = edit_addr_q;
                end
                ST_EDIT_WR: begin
                    mem_addr_out  = edit_addr_q;
                    mem_we_out    = 1'b1;
                    mem_wdata_out = word_q;
                end
                default: begin
                    mem_addr_out = render_addr_in;
                end
            endcase
        end
    end

    assign upd_gnt_out    = gnt;
    assign upd_rvalid_out = rvalid_q;
    assign rdata_out      = mem_rdata_in;
    assign edit_busy_out  = busy_q;
    assign edit_ack_out   = ack_q;
    assign gen_start_out  = gen_start_q;

endmodule

// File: tb/tb_board_mem_sched.sv
// Bench for board_mem_sched: memory model plus write/read scoreboards, one task per scenario.
module tb_board_mem_sched;
    localparam int WS  = 16;
    localparam int LWS = 4;
    localparam int AW  = 15;
    localparam int GP  = 4;

    logic            clk_130mhz = 1'b0;
    logic            rst_n_in = 1'b0;
    logic            render_done_in = 1'b0;
    logic [AW-1:0]   render_addr_in = '0;
    logic            upd_req_in = 1'b0;
    logic            upd_we_in = 1'b0;
    logic [AW-1:0]   upd_addr_in = '0;
    logic [WS-1:0]   upd_wdata_in = '0;
    logic            upd_gnt_out;
    logic            upd_rvalid_out;
    logic            edit_req_in = 1'b0;
    logic [AW-1:0]   edit_addr_in = '0;
    logic [LWS-1:0]  edit_bit_in = '0;
    logic            edit_busy_out;
    logic            edit_ack_out;
    logic            gen_start_out;
    logic [AW-1:0]   mem_addr_out;
    logic            mem_we_out;
    logic [WS-1:0]   mem_wdata_out;
    logic [WS-1:0]   mem_rdata_in = '0;
    logic [WS-1:0]   rdata_out;

    logic [WS-1:0]   mem [0:(1<<AW)-1];
    logic            pre_we = 1'b0;
    logic [AW-1:0]   pre_addr = '0;
    logic [WS-1:0]   pre_dat = '0;

    logic [AW+WS-1:0] exp_wr_q [$];
    logic [WS-1:0]    exp_rd_q [$];

    int n_checks = 0;
    int n_fail = 0;

    board_mem_sched #(
        .WORD_SIZE(WS), .LOG_WORD_SIZE(LWS), .LOG_MAX_ADDR(AW), .GEN_PERIOD(GP)
    ) dut (
        .clk_130mhz(clk_130mhz), .rst_n_in(rst_n_in),
        .render_done_in(render_done_in), .render_addr_in(render_addr_in),
        .upd_req_in(upd_req_in), .upd_we_in(upd_we_in), .upd_addr_in(upd_addr_in),
        .upd_wdata_in(upd_wdata_in), .upd_gnt_out(upd_gnt_out), .upd_rvalid_out(upd_rvalid_out),
        .edit_req_in(edit_req_in), .edit_addr_in(edit_addr_in), .edit_bit_in(edit_bit_in),
        .edit_busy_out(edit_busy_out), .edit_ack_out(edit_ack_out), .gen_start_out(gen_start_out),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in(mem_rdata_in), .rdata_out(rdata_out)
    );

    always #4 clk_130mhz = ~clk_130mhz;

    // Synchronous single-port BRAM with read-before-write.
    always @(posedge clk_130mhz) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        else if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
        mem_rdata_in <= mem[mem_addr_out];
    end

    // Scoreboard monitor: memory writes, updater read data, grant legality.
    always @(negedge clk_130mhz) begin
        logic [AW+WS-1:0] ew;
        logic [WS-1:0]    er;
        if (mem_we_out) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr_out, mem_wdata_out);
            end else begin
                ew = exp_wr_q.pop_front();
                if ({mem_addr_out, mem_wdata_out} !== ew) begin
                    n_fail++;
                    $display("FAIL write_content: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr_out, mem_wdata_out, ew[AW+WS-1:WS], ew[WS-1:0]);
                end
            end
        end
        if (upd_rvalid_out) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: got rvalid=1, expected 0");
            end else begin
                er = exp_rd_q.pop_front();
                if (rdata_out !== er) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", rdata_out, er);
                end
            end
        end
        if (upd_gnt_out) begin
            n_checks++;
            if (!render_done_in || !upd_req_in) begin
                n_fail++;
                $display("FAIL grant_legal: got gnt=1 with done=%b req=%b, expected gnt=0", render_done_in, upd_req_in);
            end
            if (!upd_we_in) exp_rd_q.push_back(mem[upd_addr_in]);
        end
    end

    task automatic tick();
        @(posedge clk_130mhz);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_130mhz);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WS-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        render_done_in = 1'b1;
        render_addr_in = 15'h0AAA;
        tick();
        preload(15'h0040, 16'hBEEF);
        preload(15'h0010, 16'h0001);
        preload(15'h0030, 16'h00F0);
        preload(15'h0050, 16'h0000);
        sample();
        n_checks++;
        if ({upd_gnt_out, upd_rvalid_out, edit_ack_out, gen_start_out, mem_we_out, edit_busy_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt/rv/ack/gen/we/busy=%b expected 000000",
                     {upd_gnt_out, upd_rvalid_out, edit_ack_out, gen_start_out, mem_we_out, edit_busy_out});
        end
        n_checks++;
        if (mem_addr_out !== 15'h0AAA) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 0aaa", mem_addr_out);
        end
        tick();
        render_done_in = 1'b0;
        rst_n_in = 1'b1;
    endtask

    task automatic test_render();
        render_addr_in = 15'h0123;
        upd_req_in = 1'b1; upd_we_in = 1'b0; upd_addr_in = 15'h0040;
        for (int i = 0; i < 6; i++) begin
            tick();
            sample();
            n_checks++;
            if (mem_addr_out !== 15'h0123 || upd_gnt_out !== 1'b0 || mem_we_out !== 1'b0) begin
                n_fail++;
                $display("FAIL render_own: got addr=%h gnt=%b we=%b, expected addr=0123 gnt=0 we=0",
                         mem_addr_out, upd_gnt_out, mem_we_out);
            end
        end
    endtask

    task automatic test_upd_read();
        int t;
        logic gen_seen;
        t = -1;
        gen_seen = 1'b0;
        tick();
        render_done_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (gen_start_out) gen_seen = 1'b1;
            if (upd_gnt_out) begin t = i; break; end
            tick();
        end
        n_checks++;
        if (t != 1) begin
            n_fail++;
            $display("FAIL upd_read_gnt_cycle: got %0d expected 1", t);
        end
        n_checks++;
        if (!gen_seen) begin
            n_fail++;
            $display("FAIL gen_start_first_blank: got 0 expected 1");
        end
        tick();
        upd_req_in = 1'b0;
        sample();
        n_checks++;
        if (upd_rvalid_out !== 1'b1 || rdata_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL upd_read_data: got rvalid=%b rdata=%h expected 1 beef", upd_rvalid_out, rdata_out);
        end
    endtask

    task automatic test_upd_write();
        logic got;
        got = 1'b0;
        tick();
        upd_req_in = 1'b1; upd_we_in = 1'b1; upd_addr_in = 15'h0041; upd_wdata_in = 16'h1234;
        exp_wr_q.push_back({15'h0041, 16'h1234});
        for (int i = 0; i < 6; i++) begin
            sample();
            if (upd_gnt_out) begin got = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL upd_write_gnt: got no grant expected grant");
        end
        tick();
        upd_req_in = 1'b0; upd_we_in = 1'b0;
    endtask

    task automatic test_edit();
        int ack_k, gnts;
        ack_k = -1;
        gnts = 0;
        upd_req_in = 1'b1; upd_we_in = 1'b0; upd_addr_in = 15'h0040;
        edit_req_in = 1'b1; edit_addr_in = 15'h0010; edit_bit_in = 4'd0;
        exp_wr_q.push_back({15'h0010, 16'h8001});
        sample();
        n_checks++;
        if (upd_gnt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL edit_beats_upd: got gnt=%b expected 0", upd_gnt_out);
        end
        tick();
        edit_addr_in = 15'h0020; edit_bit_in = 4'd3;
        sample();
        n_checks++;
        if (edit_busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL edit_busy_set: got %b expected 1", edit_busy_out);
        end
        tick();
        edit_req_in = 1'b0;
        for (int k = 2; k < 12; k++) begin
            sample();
            if (edit_ack_out) begin ack_k = k; break; end
            if (upd_gnt_out) gnts++;
            tick();
        end
        n_checks++;
        if (ack_k != 4 || gnts != 0) begin
            n_fail++;
            $display("FAIL edit_ack_timing: got ack_cycle=%0d grants=%0d expected 4 and 0", ack_k, gnts);
        end
        n_checks++;
        if (edit_busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL edit_busy_clear: got %b expected 0", edit_busy_out);
        end
        tick();
        upd_req_in = 1'b0;
        sample();
        n_checks++;
        if (edit_ack_out !== 1'b0) begin
            n_fail++;
            $display("FAIL edit_ack_pulse: got %b expected 0", edit_ack_out);
        end
    endtask

    task automatic test_abort();
        logic acked;
        acked = 1'b0;
        tick();
        edit_req_in = 1'b1; edit_addr_in = 15'h0030; edit_bit_in = 4'd5;
        tick();
        edit_req_in = 1'b0;
        tick();
        tick();
        render_done_in = 1'b0;
        sample();
        n_checks++;
        if (mem_we_out !== 1'b0 || edit_busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_wr: got we=%b busy=%b expected 0 1", mem_we_out, edit_busy_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            n_checks++;
            if (edit_busy_out !== 1'b1 || edit_ack_out !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold: got busy=%b ack=%b expected 1 0", edit_busy_out, edit_ack_out);
            end
        end
        exp_wr_q.push_back({15'h0030, 16'h04F0});
        tick();
        render_done_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (edit_ack_out) begin acked = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!acked || edit_busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_retry: got ack=%b busy=%b expected 1 0", acked, edit_busy_out);
        end
    endtask

    task automatic test_gate();
        int gens, gnts;
        logic elig;
        tick();
        rst_n_in = 1'b0; render_done_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        upd_req_in = 1'b1; upd_we_in = 1'b0; upd_addr_in = 15'h0041;
        for (int b = 1; b <= 8; b++) begin
            gens = 0; gnts = 0;
`ifdef BOARD_SCHED_FRAME_GATE_EN
            elig = ((b - 1) % GP) == 0;
`else
            elig = 1'b1;
`endif
            for (int c = 0; c < 9; c++) begin
                tick();
                render_done_in = (c >= 3);
                sample();
                if (gen_start_out) gens++;
                if (upd_gnt_out) gnts++;
            end
            n_checks++;
            if (gens != (elig ? 1 : 0) || (gnts > 0) != elig) begin
                n_fail++;
                $display("FAIL gate_blank%0d: got gen=%0d grants=%0d expected gen=%0d eligible=%b", b, gens, gnts, elig ? 1 : 0, elig);
            end
        end
        tick();
        upd_req_in = 1'b0;
    endtask

    task automatic test_reset_mid_edit();
        tick();
        render_addr_in = 15'h0777;
        edit_req_in = 1'b1; edit_addr_in = 15'h0050; edit_bit_in = 4'd1;
        tick();
        edit_req_in = 1'b0;
        tick();
        #1;
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({upd_gnt_out, upd_rvalid_out, edit_ack_out, gen_start_out, mem_we_out, edit_busy_out} !== 6'b0
            || mem_addr_out !== 15'h0777) begin
            n_fail++;
            $display("FAIL reset_mid_edit: got flags=%b addr=%h expected 000000 0777",
                     {upd_gnt_out, upd_rvalid_out, edit_ack_out, gen_start_out, mem_we_out, edit_busy_out}, mem_addr_out);
        end
        tick();
        rst_n_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            sample();
            n_checks++;
            if (edit_ack_out !== 1'b0 || edit_busy_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_discard: got ack=%b busy=%b expected 0 0", edit_ack_out, edit_busy_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_render();
        test_upd_read();
        test_upd_write();
        test_edit();
        test_abort();
        test_gate();
        test_reset_mid_edit();
        tick();
        tick();
        sample();
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d writes %0d reads pending expected 0 0", exp_wr_q.size(), exp_rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
